// File: rtl/cci_mpf_shim_wro_rsp_retire.sv
// Tracks the address hash of each WRO request issued to the FIU and emits one retire
// event per fully completed request. Multi-line and packed write responses are merged.
`timescale 1ns/1ps
module cci_mpf_shim_wro_rsp_retire #(
    parameter  int N_TAGS            = 128,
    parameter  int HASH_BITS         = 9,
    parameter  int RETIRE_FIFO_DEPTH = 8,
    localparam int TAG_W             = $clog2(N_TAGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 alloc_valid,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic [HASH_BITS-1:0] alloc_hash,
    input  logic                 alloc_is_write,
    input  logic [1:0]           alloc_num_lines,

    input  logic                 rsp_valid,
    input  logic [TAG_W-1:0]     rsp_tag,
    input  logic                 rsp_is_write,
    input  logic                 rsp_packed,

    output logic                 retire_valid,
    output logic [HASH_BITS-1:0] retire_hash,
    output logic                 retire_is_write,
    input  logic                 retire_ready,

    output logic                 rsp_almost_full,
    output logic [TAG_W:0]       active_cnt,
    output logic                 err_dup_alloc,
    output logic                 err_bad_rsp,
    output logic                 err_overflow
);

    localparam int PTR_W = $clog2(RETIRE_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Tag table
    logic [N_TAGS-1:0]    r_valid;
    logic [N_TAGS-1:0]    r_is_write;
    logic [HASH_BITS-1:0] r_hash      [N_TAGS];
    logic [1:0]           r_remaining [N_TAGS];

    // Retire FIFO: each word is {is_write, hash}
    logic [HASH_BITS:0]   r_fifo [RETIRE_FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [TAG_W:0]       r_active_cnt;
    logic                 r_err_dup;
    logic                 r_err_bad;
    logic                 r_err_ovf;

    logic w_rsp_ok;
    logic w_rsp_bad;
    logic w_final;
    logic w_dec;
    logic w_alloc_old_valid;
    logic w_alloc_new;
    logic w_dup;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Response lookup sees the table as it was before this cycle's alloc.
    assign w_rsp_ok  = rsp_valid && r_valid[rsp_tag] && (r_is_write[rsp_tag] == rsp_is_write);
    assign w_rsp_bad = rsp_valid && !w_rsp_ok;
    assign w_final   = w_rsp_ok && ((rsp_is_write && rsp_packed) || (r_remaining[rsp_tag] == 2'd0));
    assign w_dec     = w_rsp_ok && !w_final;

    // An alloc only duplicates if the old entry survives this cycle's response.
    assign w_alloc_old_valid = r_valid[alloc_tag] && !(w_final && (rsp_tag == alloc_tag));
    assign w_alloc_new       = alloc_valid && !w_alloc_old_valid;
    assign w_dup             = alloc_valid && w_alloc_old_valid;

    assign w_full = (r_count == CNT_W'(RETIRE_FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && retire_ready;
    assign w_push = w_final && (!w_full || w_pop);
    assign w_drop = w_final && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else begin
            // NOTE: both writes may hit the same bit; the later non-blocking assignment wins, so alloc overrides the retire clear.
            if (w_final)     r_valid[rsp_tag]   <= 1'b0;
            if (alloc_valid) r_valid[alloc_tag] <= 1'b1;
        end
    end

    // NOTE: table payload and FIFO storage are not reset; valid bits and the FIFO count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (w_dec) r_remaining[rsp_tag] <= r_remaining[rsp_tag] - 2'd1;
        if (alloc_valid) begin
            r_hash[alloc_tag]      <= alloc_hash;
            r_is_write[alloc_tag]  <= alloc_is_write;
            r_remaining[alloc_tag] <= alloc_num_lines;
        end
        if (w_push) r_fifo[r_wr_ptr] <= {r_is_write[rsp_tag], r_hash[rsp_tag]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active_cnt <= '0;
            r_err_dup    <= 1'b0;
            r_err_bad    <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            case ({w_alloc_new, w_final})
                2'b10:   r_active_cnt <= r_active_cnt + 1'b1;
                2'b01:   r_active_cnt <= r_active_cnt - 1'b1;
                default: r_active_cnt <= r_active_cnt;
            endcase
            r_err_dup <= r_err_dup | w_dup;
            r_err_bad <= r_err_bad | w_rsp_bad;
            r_err_ovf <= r_err_ovf | w_drop;
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign retire_valid    = (r_count != '0);
    assign retire_hash     = retire_valid ? r_fifo[r_rd_ptr][HASH_BITS-1:0] : '0;
    assign retire_is_write = retire_valid ? r_fifo[r_rd_ptr][HASH_BITS]     : 1'b0;
    assign rsp_almost_full = (r_count >= CNT_W'(RETIRE_FIFO_DEPTH - 2));
    assign active_cnt      = r_active_cnt;
    assign err_dup_alloc   = r_err_dup;
    assign err_bad_rsp     = r_err_bad;
    assign err_overflow    = r_err_ovf;

endmodule

// File: tb/tb_cci_mpf_shim_wro_rsp_retire.sv
// Directed and randomized checks of the WRO response retire block against a
// queue-based model of outstanding requests and pending retire events.
`timescale 1ns/1ps
module tb_cci_mpf_shim_wro_rsp_retire;

    localparam int N_TAGS    = 128;
    localparam int HASH_BITS = 9;
    localparam int DEPTH     = 8;
    localparam int TAG_W     = $clog2(N_TAGS);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 alloc_valid;
    logic [TAG_W-1:0]     alloc_tag;
    logic [HASH_BITS-1:0] alloc_hash;
    logic                 alloc_is_write;
    logic [1:0]           alloc_num_lines;
    logic                 rsp_valid;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_is_write;
    logic                 rsp_packed;
    logic                 retire_valid;
    logic [HASH_BITS-1:0] retire_hash;
    logic                 retire_is_write;
    logic                 retire_ready;
    logic                 rsp_almost_full;
    logic [TAG_W:0]       active_cnt;
    logic                 err_dup_alloc;
    logic                 err_bad_rsp;
    logic                 err_overflow;

    always #5 clk = ~clk;

    cci_mpf_shim_wro_rsp_retire #(
        .N_TAGS(N_TAGS), .HASH_BITS(HASH_BITS), .RETIRE_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_hash(alloc_hash),
        .alloc_is_write(alloc_is_write), .alloc_num_lines(alloc_num_lines),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_is_write(rsp_is_write),
        .rsp_packed(rsp_packed),
        .retire_valid(retire_valid), .retire_hash(retire_hash),
        .retire_is_write(retire_is_write), .retire_ready(retire_ready),
        .rsp_almost_full(rsp_almost_full), .active_cnt(active_cnt),
        .err_dup_alloc(err_dup_alloc), .err_bad_rsp(err_bad_rsp), .err_overflow(err_overflow)
    );

    // Model: outstanding requests indexed by tag, responses still owed, and a retire queue.
    typedef struct {
        logic [HASH_BITS-1:0] hash;
        bit                   wr;
    } ret_t;

    bit                   m_valid [N_TAGS];
    logic [HASH_BITS-1:0] m_hash  [N_TAGS];
    bit                   m_wr    [N_TAGS];
    int                   m_left  [N_TAGS];
    ret_t                 m_q [$];
    bit                   m_err_dup, m_err_bad, m_err_ovf;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_TAGS; i++) begin
            m_valid[i] = 1'b0;
            m_left[i]  = 0;
        end
        m_q.delete();
        m_err_dup = 1'b0;
        m_err_bad = 1'b0;
        m_err_ovf = 1'b0;
    endfunction

    // One clock of behaviour: response acts first on the old entry, then the alloc lands.
    function automatic void model_step();
        bit   fin = 1'b0;
        bit   pop;
        ret_t ev;
        ev.hash = '0;
        ev.wr   = 1'b0;
        pop = (m_q.size() > 0) && retire_ready;
        if (rsp_valid) begin
            if (!m_valid[rsp_tag] || (m_wr[rsp_tag] != rsp_is_write)) begin
                m_err_bad = 1'b1;
            end else begin
                ev.hash = m_hash[rsp_tag];
                ev.wr   = m_wr[rsp_tag];
                if ((rsp_is_write && rsp_packed) || (m_left[rsp_tag] == 1)) begin
                    fin = 1'b1;
                    m_valid[rsp_tag] = 1'b0;
                end else begin
                    m_left[rsp_tag] = m_left[rsp_tag] - 1;
                end
            end
        end
        if (alloc_valid) begin
            if (m_valid[alloc_tag]) m_err_dup = 1'b1;
            m_valid[alloc_tag] = 1'b1;
            m_hash[alloc_tag]  = alloc_hash;
            m_wr[alloc_tag]    = alloc_is_write;
            m_left[alloc_tag]  = int'(alloc_num_lines) + 1;
        end
        if (fin) begin
            if (m_q.size() == DEPTH && !pop) m_err_ovf = 1'b1;
            else                             m_q.push_back(ev);
        end
        if (pop) void'(m_q.pop_front());
    endfunction

    task automatic check_outputs();
        int act = 0;
        for (int i = 0; i < N_TAGS; i++) act += int'(m_valid[i]);
        check("retire_valid",    retire_valid,    m_q.size() > 0);
        check("retire_hash",     retire_hash,     (m_q.size() > 0) ? m_q[0].hash : '0);
        check("retire_is_write", retire_is_write, (m_q.size() > 0) ? m_q[0].wr : 1'b0);
        check("rsp_almost_full", rsp_almost_full, m_q.size() >= DEPTH - 2);
        check("active_cnt",      active_cnt,      act);
        check("err_dup_alloc",   err_dup_alloc,   m_err_dup);
        check("err_bad_rsp",     err_bad_rsp,     m_err_bad);
        check("err_overflow",    err_overflow,    m_err_ovf);
    endtask

    task automatic do_alloc(input int tag, input int hash, input bit wr, input int nl);
        alloc_valid     = 1'b1;
        alloc_tag       = TAG_W'(tag);
        alloc_hash      = HASH_BITS'(hash);
        alloc_is_write  = wr;
        alloc_num_lines = 2'(nl);
    endtask

    task automatic do_rsp(input int tag, input bit wr, input bit pk);
        rsp_valid    = 1'b1;
        rsp_tag      = TAG_W'(tag);
        rsp_is_write = wr;
        rsp_packed   = pk;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        alloc_valid = 1'b0;
        rsp_valid   = 1'b0;
        check_outputs();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int  t;
        int  base;
        bit  found;

        reset_n = 1'b0;
        alloc_valid = 1'b0; alloc_tag = '0; alloc_hash = '0; alloc_is_write = 1'b0; alloc_num_lines = '0;
        rsp_valid = 1'b0; rsp_tag = '0; rsp_is_write = 1'b0; rsp_packed = 1'b0;
        retire_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Single-line write: retire one cycle after the response
        do_alloc(5, 'h1A3, 1'b1, 0); tick();
        check("t1_active_up", active_cnt, 1);
        tick();
        do_rsp(5, 1'b1, 1'b0); tick();
        check("t1_rv", retire_valid, 1);
        check("t1_hash", retire_hash, 'h1A3);
        check("t1_wr", retire_is_write, 1);
        check("t1_active_dn", active_cnt, 0);
        tick();

        // Four-line read: only the fourth response retires
        do_alloc(7, 'h0C4, 1'b0, 3); tick();
        for (int k = 0; k < 3; k++) begin
            do_rsp(7, 1'b0, 1'b0); tick();
            check("t2_no_retire", retire_valid, 0);
        end
        do_rsp(7, 1'b0, 1'b0); tick();
        check("t2_rv", retire_valid, 1);
        check("t2_hash", retire_hash, 'h0C4);
        tick();
        check("t2_single", retire_valid, 0);
        check("t2_invalid", active_cnt, 0);

        // Packed write response retires at once; a further response is bad
        do_alloc(9, 'h055, 1'b1, 3); tick();
        do_rsp(9, 1'b1, 1'b1); tick();
        check("t3_rv", retire_valid, 1);
        tick();
        check("t3_single", retire_valid, 0);
        do_rsp(9, 1'b1, 1'b0); tick();
        check("t3_bad_rsp", err_bad_rsp, 1);

        // FIFO fill with retire_ready low, overflow on the ninth, ordered drain
        retire_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            do_alloc(20 + k, 'h100 + k, 1'b1, 0); tick();
        end
        for (int k = 1; k <= 9; k++) begin
            do_rsp(20 + k - 1, 1'b1, 1'b0); tick();
            check("t4_almost_full", rsp_almost_full, k >= 6);
            check("t4_overflow", err_overflow, k >= 9);
        end
        check("t4_head", retire_hash, 'h100);
        retire_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("t4_drained", retire_valid, 0);

        // Same-cycle final response and re-alloc of tag 3
        do_alloc(3, 'h0AA, 1'b0, 0); tick();
        do_alloc(3, 'h0BB, 1'b1, 1); do_rsp(3, 1'b0, 1'b0); tick();
        check("t5_hash_old", retire_hash, 'h0AA);
        check("t5_no_dup", err_dup_alloc, 0);
        check("t5_active", active_cnt, 1);
        tick();
        do_rsp(3, 1'b1, 1'b0); tick();
        do_rsp(3, 1'b1, 1'b0); tick();
        check("t5_hash_new", retire_hash, 'h0BB);
        tick();

        // Genuine duplicate allocation
        do_alloc(11, 'h011, 1'b0, 0); tick();
        do_alloc(11, 'h022, 1'b0, 0); tick();
        check("t5_dup", err_dup_alloc, 1);
        do_rsp(11, 1'b0, 1'b0); tick();
        tick();

        // Mid-operation reset with 4 active tags and 2 pending retires
        retire_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_alloc(40 + k, 'h040 + k, 1'b1, 0); tick();
        end
        do_rsp(40, 1'b1, 1'b0); tick();
        do_rsp(41, 1'b1, 1'b0); tick();
        reset_pulse();
        check("t6_rst_rv", retire_valid, 0);
        check("t6_rst_active", active_cnt, 0);
        check("t6_rst_bad", err_bad_rsp, 0);
        retire_ready = 1'b1;
        do_rsp(42, 1'b1, 1'b0); tick();
        check("t6_stale_rsp", err_bad_rsp, 1);

        // Randomized traffic: legal first, then occasional stray responses
        reset_pulse();
        for (int c = 0; c < 1500; c++) begin
            retire_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) begin
                t = $urandom_range(N_TAGS - 1);
                if (!m_valid[t]) do_alloc(t, $urandom_range(511), 1'($urandom_range(1)), $urandom_range(3));
            end
            if ($urandom_range(1) == 1) begin
                base  = $urandom_range(N_TAGS - 1);
                found = 1'b0;
                for (int i = 0; i < N_TAGS; i++) begin
                    t = (base + i) % N_TAGS;
                    if (!found && m_valid[t]) begin
                        do_rsp(t, m_wr[t], m_wr[t] && ($urandom_range(3) == 0));
                        found = 1'b1;
                    end
                end
            end
            if (c >= 1200 && $urandom_range(31) == 0)
                do_rsp($urandom_range(N_TAGS - 1), 1'($urandom_range(1)), 1'b0);
            tick();
        end
        retire_ready = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
